// File: rtl/adc_capture_pkg.sv
// Shared types and constants for the ADC capture controller.
package adc_capture_pkg;

   localparam int ADC_W           = 12;
   localparam int TIMEOUT_DEFAULT = 50000;

   // Capture FSM states; also exported on the debug state port.
   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_WAIT    = 2'd1,
      S_ACCUM   = 2'd2,
      S_PRESENT = 2'd3
   } state_t;

endpackage

// File: rtl/adc_capture_if.sv
// Consumer-side sample handshake between the capture controller and the servo path.
// Handshake: the master raises valid_o with sample_o stable and holds both
// unchanged until a rising clock edge sees valid_o & ready_i high; that edge is
// the transfer. ready_i may toggle freely and has no effect while valid_o is low.
interface adc_capture_if;
   import adc_capture_pkg::*;

   logic [ADC_W-1:0] sample_o;
   logic             valid_o;
   logic             ready_i;

   modport master (output sample_o, output valid_o, input ready_i);
   modport slave  (input sample_o, input valid_o, output ready_i);

endinterface

// File: rtl/adc_capture_strobe_sync.sv
// Two-flop synchronizer for the Arduino data-valid strobe plus a registered
// rising-edge detector. The edge pulse is high for one cycle, the cycle after
// the synchronized level first reads 1.
module strobe_sync (
   input  logic clk_i,
   input  logic reset,
   input  logic dataf_i,
   output logic dataf_o,
   output logic edge_o
);

   logic r_sync1;
   logic r_sync2;
   logic r_prev;
   logic r_edge;

   // Synchronize the strobe and register a one-cycle pulse on its rising edge.
   always_ff @(posedge clk_i) begin
      if (!reset) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_prev  <= 1'b0;
         r_edge  <= 1'b0;
      end else begin
         r_sync1 <= dataf_i;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
         r_edge  <= r_sync2 & ~r_prev;
      end
   end

   assign dataf_o = r_sync2;
   assign edge_o  = r_edge;

endmodule

// File: rtl/adc_capture_ctrl.sv
// ADC capture controller: takes strobed 12-bit conversions from an Arduino,
// optionally averages 2^AVG_LOG2 of them, and presents the result on a
// valid/ready port. Flags a WAIT timeout and strobes dropped while presenting.
// Build option: define ADC_CAPTURE_AVG_EN to enable averaging; without it
// each captured sample is presented unmodified.
module adc_capture_ctrl
   import adc_capture_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
   parameter int AVG_LOG2       = 2
) (
   input  logic             clk_i,
   input  logic             reset,
   input  logic             enable_i,
   input  logic [ADC_W-1:0] arduino_i,
   input  logic             dataf_i,
   adc_capture_if.master    cons,
   output logic             dataf_o,
   output logic [ADC_W-1:0] LEDS_o,
   output logic             timeout_o,
   output logic             overrun_o,
   output state_t           dbg_state_o
);

`ifdef ADC_CAPTURE_AVG_EN
   localparam int SHIFT = AVG_LOG2;
`else
   // Averaging off: one sample per result, so the shift collapses to zero.
   localparam int SHIFT = 0 * AVG_LOG2;
`endif
   localparam int ACC_W = ADC_W + SHIFT;
   localparam int CNT_W = SHIFT + 1;
   localparam int TO_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(1 << SHIFT);
   localparam logic [TO_W-1:0]  TO_MAX     = TO_W'(TIMEOUT_CYCLES - 1);

   state_t           r_state;
   state_t           w_next;
   logic             w_edge;
   logic             w_valid;
   logic             w_xfer;
   logic             w_count_done;
   logic [ADC_W-1:0] w_avg;
   logic [ACC_W-1:0] r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic [TO_W-1:0]  r_to_cnt;
   logic [ADC_W-1:0] r_sample;
   logic [ADC_W-1:0] r_leds;
   logic             r_timeout;
   logic             r_overrun;

   strobe_sync u_sync (
      .clk_i   (clk_i),
      .reset   (reset),
      .dataf_i (dataf_i),
      .dataf_o (dataf_o),
      .edge_o  (w_edge)
   );

   assign w_valid      = (r_state == S_PRESENT);
   assign w_xfer       = w_valid & cons.ready_i;
   assign w_count_done = (r_cnt == CNT_TARGET);
   // Sum of 2^SHIFT 12-bit samples fits ACC_W bits exactly; truncating shift.
   assign w_avg        = ADC_W'(r_acc >> SHIFT);

   // FSM state register.
   always_ff @(posedge clk_i) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // FSM next state; disable overrides everything and parks in IDLE.
   always_comb begin
      w_next = r_state;
      if (!enable_i) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:    w_next = S_WAIT;
            S_WAIT:    if (w_edge) w_next = S_ACCUM;
            S_ACCUM:   w_next = w_count_done ? S_PRESENT : S_WAIT;
            S_PRESENT: if (w_xfer) w_next = S_WAIT;
            default:   w_next = S_IDLE;
         endcase
      end
   end

   // Datapath: accumulate, time out in WAIT, latch result, track sticky flags.
   always_ff @(posedge clk_i) begin
      if (!reset) begin
         r_acc     <= '0;
         r_cnt     <= '0;
         r_to_cnt  <= '0;
         r_sample  <= '0;
         r_leds    <= '0;
         r_timeout <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         if (w_xfer) r_leds <= r_sample;
         if (!enable_i) begin
            r_acc     <= '0;
            r_cnt     <= '0;
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
            r_overrun <= 1'b0;
         end else begin
            case (r_state)
               S_WAIT: begin
                  if (w_edge) begin
                     r_acc    <= r_acc + ACC_W'(arduino_i);
                     r_cnt    <= r_cnt + CNT_W'(1);
                     r_to_cnt <= '0;
                  end else if (r_to_cnt == TO_MAX) begin
                     // Source went quiet: drop the partial group and keep waiting.
                     r_timeout <= 1'b1;
                     r_acc     <= '0;
                     r_cnt     <= '0;
                     r_to_cnt  <= '0;
                  end else begin
                     r_to_cnt <= r_to_cnt + TO_W'(1);
                  end
               end
               S_ACCUM: begin
                  r_to_cnt <= '0;
                  if (w_count_done) r_sample <= w_avg;
               end
               S_PRESENT: begin
                  r_to_cnt <= '0;
                  if (w_edge) r_overrun <= 1'b1;
                  if (w_xfer) begin
                     r_acc <= '0;
                     r_cnt <= '0;
                  end
               end
               default: r_to_cnt <= '0;
            endcase
         end
      end
   end

   assign cons.valid_o  = w_valid;
   assign cons.sample_o = r_sample;
   assign LEDS_o        = r_leds;
   assign timeout_o     = r_timeout;
   assign overrun_o     = r_overrun;
   assign dbg_state_o   = r_state;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Bench for adc_capture_ctrl: directed scenarios plus randomized sample groups,
// checked against a transaction-level averaging model.
module tb_adc_capture_ctrl;
   import adc_capture_pkg::*;

   localparam int AVG_LOG2_TB = 2;
`ifdef ADC_CAPTURE_AVG_EN
   localparam int L = AVG_LOG2_TB;
`else
   localparam int L = 0;
`endif
   localparam int N_AVG = 1 << L;

   logic             clk;
   logic             reset;
   logic             enable;
   logic [ADC_W-1:0] arduino;
   logic             dataf;
   logic             dataf_o;
   logic [ADC_W-1:0] leds;
   logic             timeout;
   logic             overrun;
   state_t           dbg_state;
   bit               rnd_ready;

   adc_capture_if cons_if ();

   adc_capture_ctrl #(.TIMEOUT_CYCLES(16), .AVG_LOG2(AVG_LOG2_TB)) dut (
      .clk_i       (clk),
      .reset       (reset),
      .enable_i    (enable),
      .arduino_i   (arduino),
      .dataf_i     (dataf),
      .cons        (cons_if),
      .dataf_o     (dataf_o),
      .LEDS_o      (leds),
      .timeout_o   (timeout),
      .overrun_o   (overrun),
      .dbg_state_o (dbg_state)
   );

   // Clock and watchdog.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   // Counters and the single checking task.
   int n_vec  = 0;
   int n_miss = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: groups of N_AVG counted samples average to sum >> L.
   logic [ADC_W-1:0] part_q[$];
   logic [ADC_W-1:0] exp_q[$];
   int               exp_total = 0;
   int               xfer_cnt  = 0;

   function automatic void model_add(input logic [ADC_W-1:0] v);
      int unsigned sum;
      part_q.push_back(v);
      if (part_q.size() == N_AVG) begin
         sum = 0;
         foreach (part_q[i]) sum += part_q[i];
         exp_q.push_back(ADC_W'(sum >> L));
         exp_total++;
         part_q.delete();
      end
   endfunction

   function automatic void model_discard();
      part_q.delete();
   endfunction

   function automatic void model_flush();
      exp_total -= exp_q.size();
      exp_q.delete();
      part_q.delete();
   endfunction

   // Scoreboard monitor: transfers, LEDS follow-up, sample hold while stalled.
   logic [ADC_W-1:0] prev_sample;
   logic [ADC_W-1:0] leds_exp;
   bit               prev_valid = 0;
   bit               prev_xfer  = 0;
   bit               leds_pend  = 0;

   always @(negedge clk) begin
      if (!reset) begin
         prev_valid = 0;
         prev_xfer  = 0;
         leds_pend  = 0;
      end else begin
         if (leds_pend) begin
            check_eq("leds_after_xfer", leds, leds_exp);
            leds_pend = 0;
         end
         if (cons_if.valid_o && prev_valid && !prev_xfer)
            check_eq("sample_hold", cons_if.sample_o, prev_sample);
         prev_xfer = 0;
         if (cons_if.valid_o && cons_if.ready_i) begin
            xfer_cnt++;
            prev_xfer = 1;
            if (exp_q.size() == 0) begin
               check_eq("xfer_unexpected", cons_if.valid_o, 1'b0);
            end else begin
               leds_exp = exp_q.pop_front();
               check_eq("xfer_sample", cons_if.sample_o, leds_exp);
               leds_pend = 1;
            end
         end
         prev_valid  = cons_if.valid_o;
         prev_sample = cons_if.sample_o;
      end
   end

   // Driver tasks.
   task automatic step();
      @(posedge clk);
      #1;
      if (rnd_ready) cons_if.ready_i = ($urandom_range(0, 3) != 0);
   endtask

   task automatic strobe(input logic [ADC_W-1:0] v, input int gap, input bit counted, input bit timed);
      if (counted) model_add(v);
      arduino = v;
      dataf   = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         step();
         if (timed) begin
            if (k == 1) check_eq("dataf_o_not_yet", dataf_o, 1'b0);
            if (k == 2) check_eq("dataf_o_sync", dataf_o, 1'b1);
            if (k == 4) check_eq("valid_early", cons_if.valid_o, 1'b0);
            if (k == 5) begin
               check_eq("valid_at_5", cons_if.valid_o, 1'b1);
               check_eq("sample_5a3", cons_if.sample_o, 12'h5A3);
            end
         end
         if (k == 4) dataf = 1'b0;
      end
      repeat (gap) step();
   endtask

   task automatic group_rand(input int max_gap);
      for (int i = 0; i < N_AVG; i++)
         strobe(ADC_W'($urandom_range(0, 4095)), $urandom_range(0, max_gap), 1'b1, 1'b0);
   endtask

   task automatic wait_xfer();
      int n;
      n = 0;
      while (xfer_cnt != exp_total && n < 200) begin
         step();
         n++;
      end
      check_eq("xfer_count", xfer_cnt, exp_total);
      step();
   endtask

   task automatic restart();
      enable = 1'b0;
      repeat (3) step();
      model_flush();
      enable = 1'b1;
      step();
   endtask

   // Stimulus sequence.
   logic [ADC_W-1:0] avg_tab [4] = '{12'd100, 12'd101, 12'd102, 12'd104};
   logic [ADC_W-1:0] v;

   initial begin
      reset = 1'b0; enable = 1'b0; dataf = 1'b0; arduino = '0;
      cons_if.ready_i = 1'b0; rnd_ready = 1'b0;
      repeat (3) step();
      check_eq("rst_valid", cons_if.valid_o, 1'b0);
      check_eq("rst_sample", cons_if.sample_o, 12'h000);
      check_eq("rst_leds", leds, 12'h000);
      check_eq("rst_timeout", timeout, 1'b0);
      check_eq("rst_overrun", overrun, 1'b0);
      check_eq("rst_dataf_o", dataf_o, 1'b0);
      check_eq("rst_state", dbg_state, S_IDLE);
      reset = 1'b1;
      step();

      // Single conversion, latency and passthrough value.
      cons_if.ready_i = 1'b1;
      enable = 1'b1;
      step();
      for (int i = 0; i < N_AVG - 1; i++) strobe(12'h5A3, 0, 1'b1, 1'b0);
      strobe(12'h5A3, 0, 1'b1, 1'b1);
      wait_xfer();
      check_eq("leds_5a3", leds, 12'h5A3);

      // Averaging table.
      foreach (avg_tab[i]) strobe(avg_tab[i], 1, 1'b1, 1'b0);
      wait_xfer();
`ifdef ADC_CAPTURE_AVG_EN
      check_eq("avg_result", leds, 12'd101);
`else
      check_eq("last_raw", leds, 12'd104);
`endif

      // Stall in PRESENT with an extra strobe: held sample, overrun, strobe dropped.
      cons_if.ready_i = 1'b0;
      group_rand(0);
      strobe(ADC_W'($urandom_range(0, 4095)), 0, 1'b0, 1'b0);
      repeat (3) step();
      check_eq("stall_overrun", overrun, 1'b1);
      check_eq("stall_valid", cons_if.valid_o, 1'b1);
      check_eq("stall_sample", cons_if.sample_o, exp_q[0]);
      cons_if.ready_i = 1'b1;
      wait_xfer();
      repeat (10) step();
      check_eq("no_extra_valid", cons_if.valid_o, 1'b0);
      group_rand(2);
      wait_xfer();

      // Randomized groups with random consumer back-pressure.
      restart();
      rnd_ready = 1'b1;
      for (int g = 0; g < 24; g++) begin
         group_rand(4);
         wait_xfer();
      end
      rnd_ready = 1'b0;
      cons_if.ready_i = 1'b1;
      check_eq("rand_no_timeout", timeout, 1'b0);
      check_eq("rand_no_overrun", overrun, 1'b0);

      // Timeout after 16 quiet cycles in WAIT; partial group discarded.
      enable = 1'b0;
      repeat (3) step();
      model_flush();
      enable = 1'b1;
      repeat (16) step();
      check_eq("timeout_not_yet", timeout, 1'b0);
      step();
      check_eq("timeout_set", timeout, 1'b1);
      strobe(ADC_W'($urandom_range(0, 4095)), 0, 1'b1, 1'b0);
      repeat (20) step();
      model_discard();
      group_rand(0);
      wait_xfer();
      check_eq("timeout_sticky", timeout, 1'b1);

      // Disable mid-ACCUM: partial dropped, flags cleared, averaging restarts.
      for (int i = 0; i < N_AVG - 1; i++) strobe(ADC_W'($urandom_range(0, 4095)), 0, 1'b1, 1'b0);
      v = ADC_W'($urandom_range(0, 4095));
      arduino = v;
      dataf = 1'b1;
      repeat (4) step();
      check_eq("accum_state", dbg_state, S_ACCUM);
      enable = 1'b0;
      dataf = 1'b0;
      step();
      check_eq("dis_state", dbg_state, S_IDLE);
      check_eq("dis_valid", cons_if.valid_o, 1'b0);
      check_eq("dis_timeout", timeout, 1'b0);
      check_eq("dis_overrun", overrun, 1'b0);
      model_discard();
      repeat (3) step();
      enable = 1'b1;
      step();
      group_rand(1);
      wait_xfer();

      // Reset while presenting: everything returns to zero, no transfer.
      cons_if.ready_i = 1'b0;
      group_rand(0);
      strobe(ADC_W'($urandom_range(0, 4095)), 0, 1'b0, 1'b0);
      check_eq("pre_rst_valid", cons_if.valid_o, 1'b1);
      check_eq("pre_rst_overrun", overrun, 1'b1);
      reset = 1'b0;
      step();
      check_eq("mid_rst_valid", cons_if.valid_o, 1'b0);
      check_eq("mid_rst_sample", cons_if.sample_o, 12'h000);
      check_eq("mid_rst_leds", leds, 12'h000);
      check_eq("mid_rst_overrun", overrun, 1'b0);
      check_eq("mid_rst_timeout", timeout, 1'b0);
      check_eq("mid_rst_dataf_o", dataf_o, 1'b0);
      model_flush();
      step();
      reset = 1'b1;
      cons_if.ready_i = 1'b1;
      step();
      group_rand(1);
      wait_xfer();

      check_eq("exp_q_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
